// File: rtl/fifo_reader.sv
// Read-side burst controller: pulls words from a registered-output FIFO into a 2-entry
// buffer and emits them on valid/ready. Optional stall abort: FIFO_READER_TIMEOUT_EN.
module fifo_reader #(
    parameter int  DATA_WIDTH = 8,
    parameter int  BURST_MAX  = 8,
    parameter int  TIMEOUT    = 16,
    localparam int CW         = $clog2(BURST_MAX + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [CW-1:0]         i_burst_len,
    output logic                  o_fifo_rden,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [CW-1:0]         o_word_cnt
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            r_state_next;
    logic [CW-1:0]         r_len;
    logic [CW-1:0]         r_issued;
    logic [CW-1:0]         r_word_cnt;
    logic                  r_pend;
    logic [1:0]            r_occ;
    logic [DATA_WIDTH-1:0] r_buf [2];

    logic                  w_pop;
    logic                  w_fire;
    logic                  w_start_ok;
    logic                  w_flush_done;
    logic                  w_tmo_hit;
    logic [CW-1:0]         w_len_sat;
    logic [2:0]            w_need;
    logic [2:0]            w_cap;

    assign o_m_valid    = (r_occ != 2'd0);
    assign o_m_data     = r_buf[0];
    assign w_pop        = o_m_valid & i_m_ready;
    assign w_start_ok   = (r_state == S_IDLE) & i_start;
    assign w_len_sat    = (i_burst_len > CW'(BURST_MAX)) ? CW'(BURST_MAX) : i_burst_len;

    // Credit: a read may fire only if its word has a slot when it lands next cycle.
    assign w_need       = {1'b0, r_occ} + {2'b00, r_pend};
    assign w_cap        = 3'd2 + {2'b00, w_pop};
    assign w_fire       = (r_state == S_READ) & ~i_fifo_empty & (r_issued < r_len) & (w_need < w_cap);
    assign o_fifo_rden  = w_fire;

    // Leaving FLUSH as the last word pops lets done follow the final pop directly.
    assign w_flush_done = ~r_pend & ((r_occ == 2'd0) | ((r_occ == 2'd1) & w_pop));

    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);
    assign o_word_cnt   = r_word_cnt;

`ifdef FIFO_READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_tmo;
    logic          r_err;
    logic          w_stall;

    assign w_stall   = (r_state == S_READ) & i_fifo_empty & (r_issued < r_len);
    assign w_tmo_hit = w_stall & (r_tmo == TW'(TIMEOUT - 1));
    assign o_err     = r_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_tmo <= w_stall ? r_tmo + 1'b1 : '0;
            if (w_start_ok)
                r_err <= 1'b0;
            else if (w_tmo_hit)
                r_err <= 1'b1;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
    assign o_err     = 1'b0;
`endif

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) r_state_next = (w_len_sat == '0) ? S_DONE : S_READ;
            S_READ:  if (w_tmo_hit || (r_issued == r_len)) r_state_next = S_FLUSH;
            S_FLUSH: if (w_flush_done) r_state_next = S_DONE;
            S_DONE:  r_state_next = S_IDLE;
            default: r_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_issued   <= '0;
            r_word_cnt <= '0;
            r_pend     <= 1'b0;
        end else begin
            r_state <= r_state_next;
            r_pend  <= w_fire;
            if (w_start_ok) begin
                r_len      <= w_len_sat;
                r_issued   <= '0;
                r_word_cnt <= '0;
            end else begin
                if (w_fire) r_issued <= r_issued + 1'b1;
                if (w_pop)  r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    // Head lives in r_buf[0]; a pop shifts, a push lands behind whatever remains.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_occ    <= 2'd0;
            r_buf[0] <= '0;
            r_buf[1] <= '0;
        end else begin
            case ({r_pend, w_pop})
                2'b11: begin
                    if (r_occ == 2'd2) begin
                        r_buf[0] <= r_buf[1];
                        r_buf[1] <= i_fifo_data;
                    end else begin
                        r_buf[0] <= i_fifo_data;
                    end
                end
                2'b10: begin
                    if (r_occ == 2'd0) r_buf[0] <= i_fifo_data;
                    else               r_buf[1] <= i_fifo_data;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf[0] <= r_buf[1];
                    r_occ    <= r_occ - 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: behavioural registered-output FIFO upstream,
// per-cycle stream monitor downstream, immediate-assertion checks.
module tb_fifo_reader;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] burst_len = '0;
    logic          fifo_rden;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          busy, done, err;
    logic [CW-1:0] word_cnt;

    int vectors = 0;
    int fails   = 0;

    fifo_reader #(.DATA_WIDTH(DW), .BURST_MAX(8), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_burst_len(burst_len),
        .o_fifo_rden(fifo_rden), .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data),
        .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data),
        .o_busy(busy), .o_done(done), .o_err(err), .o_word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // Upstream FIFO: o_data registered one cycle after rden.
    logic [DW-1:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rden && !fifo_empty) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Stream monitor, sampled late in each cycle after inputs have settled.
    int            rden_cnt = 0, rden_viol = 0, done_cnt = 0, stall_viol = 0;
    logic [DW-1:0] rx_q [$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            if (fifo_rden) rden_cnt++;
            if (fifo_rden && fifo_empty) rden_viol++;
            if (done) done_cnt++;
            if (m_valid && m_ready) rx_q.push_back(m_data);
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data)) stall_viol++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fpush(input logic [DW-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
    endtask

    task automatic kick(input logic [CW-1:0] len);
        @(negedge clk);
        burst_len = len;
        start     = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
        @(negedge clk);
        #3;
    endtask

    task automatic check_rx(input string tag, input int base, input logic [DW-1:0] first, input int n);
        check({tag, "_count"}, 32'(rx_q.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < rx_q.size())
                check({tag, "_word"}, 32'(rx_q[base + i]), 32'(first + DW'(i)));
        end
    endtask

    logic          exp_rden  [1:8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic          exp_valid [1:8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    logic [DW-1:0] exp_data  [1:8] = '{8'h00, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00, 8'h00};
    logic          exp_done  [1:8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    logic          exp_busy  [1:8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    logic          rdy_pat   [0:3] = '{1, 0, 0, 1};

    int b_rx, b_rden, b_done, b_viol, b_stall;
    bit seen;

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_rden", 32'(fifo_rden), 0);
        check("rst_valid", 32'(m_valid), 0);
        check("rst_data", 32'(m_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_wcnt", 32'(word_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic 4-word burst, cycle-accurate
        for (int i = 0; i < 4; i++) fpush(8'h11 + 8'(i));
        b_rx = rx_q.size(); b_rden = rden_cnt;
        kick(4);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            check($sformatf("t1_rden_c%0d", c), 32'(fifo_rden), 32'(exp_rden[c]));
            check($sformatf("t1_valid_c%0d", c), 32'(m_valid), 32'(exp_valid[c]));
            if (exp_valid[c]) check($sformatf("t1_data_c%0d", c), 32'(m_data), 32'(exp_data[c]));
            check($sformatf("t1_done_c%0d", c), 32'(done), 32'(exp_done[c]));
            check($sformatf("t1_busy_c%0d", c), 32'(busy), 32'(exp_busy[c]));
        end
        #2;
        check("t1_wcnt", 32'(word_cnt), 4);
        check("t1_rden_cnt", 32'(rden_cnt - b_rden), 4);
        check_rx("t1_rx", b_rx, 8'h11, 4);

        // Back-pressure with m_ready 1,0,0,1,...
        for (int i = 0; i < 4; i++) fpush(8'h21 + 8'(i));
        b_rx = rx_q.size(); b_done = done_cnt; b_stall = stall_viol;
        kick(4);
        m_ready = rdy_pat[0];
        seen = 1'b0;
        for (int c = 1; c < 60; c++) begin
            @(negedge clk);
            start   = 1'b0;
            m_ready = rdy_pat[c % 4];
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("t2_done_seen", 32'(seen), 1);
        @(negedge clk);
        m_ready = 1'b1;
        #3;
        check_rx("t2_rx", b_rx, 8'h21, 4);
        check("t2_stall_hold", 32'(stall_viol - b_stall), 0);
        check("t2_wcnt", 32'(word_cnt), 4);
        check("t2_done_cnt", 32'(done_cnt - b_done), 1);

        // FIFO runs dry mid-burst, refilled 10 cycles later
        fpush(8'h31); fpush(8'h32);
        b_rx = rx_q.size(); b_rden = rden_cnt; b_viol = rden_viol; b_done = done_cnt;
        kick(4);
        seen = 1'b0;
        for (int c = 1; c < 60; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 10) begin
                fpush(8'h33); fpush(8'h34);
            end
            #1;
            if (c == 8) check("t3_wait_busy", 32'(busy), 1);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("t3_done_seen", 32'(seen), 1);
        @(negedge clk);
        #3;
        check("t3_rden_empty", 32'(rden_viol - b_viol), 0);
        check("t3_rden_cnt", 32'(rden_cnt - b_rden), 4);
        check_rx("t3_rx", b_rx, 8'h31, 4);
        check("t3_done_cnt", 32'(done_cnt - b_done), 1);

        // Zero-length burst
        b_rden = rden_cnt;
        kick(0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("t4_len0_done_c1", 32'(done), 1);
        check("t4_len0_busy_c1", 32'(busy), 1);
        check("t4_len0_rden_c1", 32'(fifo_rden), 0);
        @(negedge clk);
        #1;
        check("t4_len0_done_c2", 32'(done), 0);
        check("t4_len0_busy_c2", 32'(busy), 0);
        check("t4_len0_wcnt", 32'(word_cnt), 0);
        check("t4_len0_rden_cnt", 32'(rden_cnt - b_rden), 0);

        // start while busy is ignored
        fpush(8'h41); fpush(8'h42);
        b_rx = rx_q.size(); b_rden = rden_cnt;
        kick(2);
        @(negedge clk);
        start = 1'b0;
        kick(5);
        wait_done("t4_busy_done", 40);
        check("t4_busy_rden_cnt", 32'(rden_cnt - b_rden), 2);
        check("t4_busy_wcnt", 32'(word_cnt), 2);
        check("t4_busy_idle", 32'(busy), 0);
        check_rx("t4_busy_rx", b_rx, 8'h41, 2);

        // burst_len above BURST_MAX saturates
        for (int i = 0; i < 9; i++) fpush(8'h61 + 8'(i));
        b_rx = rx_q.size(); b_rden = rden_cnt;
        kick(15);
        wait_done("t4_sat_done", 60);
        check("t4_sat_rden_cnt", 32'(rden_cnt - b_rden), 8);
        check("t4_sat_wcnt", 32'(word_cnt), 8);
        check_rx("t4_sat_rx", b_rx, 8'h61, 8);
        wr_ptr = rd_ptr;

        // Asynchronous reset while a read is pending
        for (int i = 0; i < 4; i++) fpush(8'h51 + 8'(i));
        kick(4);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        check("t5_pre_valid", 32'(m_valid), 1);
        rst = 1'b1;
        #1;
        check("t5_rst_rden", 32'(fifo_rden), 0);
        check("t5_rst_valid", 32'(m_valid), 0);
        check("t5_rst_data", 32'(m_data), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_done", 32'(done), 0);
        check("t5_rst_err", 32'(err), 0);
        check("t5_rst_wcnt", 32'(word_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        fpush(8'h55);
        b_rx = rx_q.size();
        kick(2);
        wait_done("t5_after_done", 40);
        check("t5_after_wcnt", 32'(word_cnt), 2);
        check_rx("t5_after_rx", b_rx, 8'h54, 2);

`ifdef FIFO_READER_TIMEOUT_EN
        // Stall abort
        fpush(8'h71);
        b_rx = rx_q.size();
        kick(3);
        wait_done("t6_tmo_done", 80);
        check("t6_tmo_err", 32'(err), 1);
        check("t6_tmo_wcnt", 32'(word_cnt), 1);
        check_rx("t6_tmo_rx", b_rx, 8'h71, 1);
        kick(0);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("t6_err_clear", 32'(err), 0);
        @(negedge clk);
`else
        check("t6_err_tied", 32'(err), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller for the minilab single-clock FIFO. It pulls a programmed burst of words out of an upstream FIFO through its `rden`/`empty`/registered `o_data` port and re-emits them on a valid/ready stream. A 2-entry output buffer provides back-pressure isolation. The block sits between a FIFO and a downstream consumer such as a MAC lane, and signals burst completion.

## Interface
- `DATA_WIDTH`, 8, FIFO word and stream data width.
- `BURST_MAX`, 8, largest burst; `CW = $clog2(BURST_MAX+1)`.
- `TIMEOUT`, 16, stall cycles before abort. Used only with `FIFO_READER_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: burst request pulse; sampled only in IDLE.
- `burst_len` in CW: words to read; latched on accepted `start`.
- `fifo_rden` out 1: read strobe to FIFO `rden`.
- `fifo_empty` in 1: FIFO `empty`.
- `fifo_data` in DATA_WIDTH: FIFO `o_data`; valid the cycle after a read fire.
- `m_valid` out 1: stream data valid.
- `m_ready` in 1: stream consumer ready.
- `m_data` out DATA_WIDTH: stream data.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: 1-cycle completion pulse.
- `err` out 1: burst aborted by timeout; sticky until next accepted `start`.
- `word_cnt` out CW: words accepted on the stream in the current or last burst.

## Operation
- FSM states:
  - **IDLE**: `start` moves to READ. If the latched length is 0, it moves to DONE instead.
  - **READ**: issue reads. Moves to FLUSH when issued reads equal the latched length.
  - **FLUSH**: wait until nothing is pending and the buffer is empty, then move to DONE.
  - **DONE**: assert `done` for one cycle, then return to IDLE.
- `burst_len` values greater than `BURST_MAX` saturate to `BURST_MAX`. Latching `start` clears `word_cnt`, `err`, and the issued count.
- `fifo_rden = (state==READ) & !fifo_empty & (issued < len) & (occ + pend < 2 + pop)`.
  - `pop = m_valid & m_ready`.
  - `occ` is buffer occupancy (0–2).
  - `pend` is a read fired in the previous cycle.
  - The strobe is never asserted while `fifo_empty` is high.
- Read fire means `fifo_rden` is high at a clock edge. That edge sets `pend` and increments `issued`.
- While `pend` is high, `fifo_data` is written into the buffer tail at the end of that cycle.
- `m_data` is the buffer head, and `m_valid = (occ != 0)`. `m_data` and `m_valid` hold stable while `m_valid & !m_ready`.
- Each pop increments `word_cnt`.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - Order is preserved.
  - A push into a full buffer cannot occur, by the credit rule.
- `start` is ignored while `busy` is high.
- Asynchronous `rst` mid-burst returns to IDLE and clears the buffer, `pend`, and all counters.
  - A word fired before reset is lost, because the FIFO pointer has already advanced. This is accepted behaviour.

## Timing
- Reset values: `fifo_rden`=0, `m_valid`=0, `m_data`=0, `busy`=0, `done`=0, `err`=0, `word_cnt`=0. State is IDLE.
- Cycle numbering for a burst with a non-empty FIFO:
  - `start` high in cycle 0.
  - Cycle 1: READ, first `fifo_rden` high.
  - Cycle 2: `fifo_data` valid.
  - Cycle 3: `m_valid` high. Start-to-first-data latency is 3 cycles.
- With `m_ready` held high and the FIFO non-empty, throughput is 1 word per cycle.
- `done` is high in the cycle after the last pop and FLUSH exit. `busy` falls in the same cycle that `done` falls.
- The length-0 burst sequence is `start` (cycle 0), DONE (cycle 1), IDLE (cycle 2). No `fifo_rden` is issued.

## Configuration
- `FIFO_READER_TIMEOUT_EN` defined:
  - A counter counts consecutive READ cycles with `fifo_empty` high and `issued < len`. It clears on any read fire.
  - When the count reaches `TIMEOUT`, the FSM moves to FLUSH and sets `err`=1.
  - Already-fetched words still drain. `done` pulses as normal, and `word_cnt` reports the delivered count.
- `FIFO_READER_TIMEOUT_EN` undefined:
  - No counter exists and `err` is tied 0.
  - READ waits indefinitely for data.

## Test plan
- Reset, then FIFO preloaded 0x11..0x14, `burst_len`=4, `m_ready`=1, `start` in cycle 0 -> `m_data` = 0x11, 0x12, 0x13, 0x14 in cycles 3–6. Exactly 4 `fifo_rden` cycles, `done` in cycle 7, `word_cnt`=4.
- Same burst with `m_ready` toggling 1,0,0,1,... -> no word dropped or duplicated, `occ` never exceeds 2, and `m_data` holds stable during stalls.
- FIFO holds 2 words, `burst_len`=4; 2 more words written 10 cycles later -> `fifo_rden` is never high while `fifo_empty`=1. All 4 words arrive in order and `done` pulses.
- `burst_len`=0 -> `done` in cycle 1, no `fifo_rden`, `word_cnt`=0. A `start` pulse during a busy burst is ignored.
- `rst` asserted mid-burst, when `pend`=1 -> all outputs return to reset values immediately. A following `burst_len`=2 burst operates normally.
- With `FIFO_READER_TIMEOUT_EN`: FIFO holds 1 word, `burst_len`=3, `TIMEOUT`=16 -> one word is delivered, then `err`=1, `done` pulses, and `word_cnt`=1.
